// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Pipelined barrel shifter on W = 2**N bit words. Supports logical shift left,
//   logical shift right, arithmetic shift right and rotate right, selected per
//   word. There is one register stage per amount bit. Stage s shifts by 2**s
//   when bit s of the amount is set. A valid/ready handshake on each side lets
//   the block sustain one word per clock. The whole pipe freezes when the
//   output is held.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_data/in_amt/in_op are valid this cycle
//   in_ready   shifter accepts a word this cycle (low only while stalled)
//   in_data    operand, W bits
//   in_amt     shift amount, N bits (0..W-1)
//   in_op      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid  out_data holds a result
//   out_ready  downstream accepts out_data this cycle
//   out_data   shifted result, W bits
//   out_zero   out_data == 0, qualified by out_valid
module pipelined_barrel_shifter #(
  parameter int N   = 3,
  parameter int OPW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   in_data,
  input  logic [N-1:0]      in_amt,
  input  logic [OPW-1:0]    in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_data,
  output logic              out_zero
);

  localparam int W = 2**N;

  localparam logic [OPW-1:0] OP_LSL = 2'b00;
  localparam logic [OPW-1:0] OP_LSR = 2'b01;
  localparam logic [OPW-1:0] OP_ASR = 2'b10;

  // Shift by a fixed distance k. Each stage uses its own MSB as the ASR fill.
  // Because every stage is arithmetic, the original sign bit carries through.
  function automatic logic [W-1:0] shift_by(input logic [W-1:0] d,
                                            input logic [OPW-1:0] op,
                                            input int k);
    logic [W-1:0] r;
    case (op)
      OP_LSL:  r = d << k;
      OP_LSR:  r = d >> k;
      OP_ASR:  r = $signed(d) >>> k;
      default: r = (d >> k) | (d << (W - k));
    endcase
    return r;
  endfunction

  logic stall;
  logic zero_q;

  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int K  = 2**s;
    // Amount bits that are not yet applied when a word enters this stage.
    localparam int AW = N - s;

    logic [W-1:0]   d_in;
    logic [W-1:0]   d_sh;
    logic [W-1:0]   d_q;
    logic [AW-1:0]  a_in;
    logic [OPW-1:0] op_in;
    logic           v_in;
    logic           v_q;

    if (s == 0) begin : g_src
      assign d_in  = in_data;
      assign a_in  = in_amt;
      assign op_in = in_op;
      assign v_in  = in_valid;
    end else begin : g_src
      assign d_in  = g_stage[s-1].d_q;
      assign a_in  = g_stage[s-1].g_fwd.a_q;
      assign op_in = g_stage[s-1].g_fwd.op_q;
      assign v_in  = g_stage[s-1].v_q;
    end

    assign d_sh = a_in[0] ? shift_by(d_in, op_in, K) : d_in;

    // A bubble loads valid=0. Its data is don't-care, so it is not gated.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_q <= '0;
        v_q <= 1'b0;
      end else if (!stall) begin
        d_q <= d_sh;
        v_q <= v_in;
      end
    end

    // The last stage consumes the final amount bit and the op, so it
    // has no further control to forward.
    if (s < N-1) begin : g_fwd
      logic [AW-2:0]  a_q;
      logic [OPW-1:0] op_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q  <= '0;
          op_q <= '0;
        end else if (!stall) begin
          a_q  <= a_in[AW-1:1];
          op_q <= op_in;
        end
      end
    end
  end

  // The zero flag is registered alongside the final data stage. It is
  // gated with valid so that the flag reads 0 on bubbles and after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
    end else if (!stall) begin
      zero_q <= g_stage[N-1].v_in & ~|g_stage[N-1].d_sh;
    end
  end

  assign out_valid = g_stage[N-1].v_q;
  assign out_data  = g_stage[N-1].d_q;
  assign out_zero  = zero_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (N=3, W=8). The bench checks
// single words against hand-computed results. It then checks streams, with
// and without a stall, for order, count and output hold. It checks reset in
// the middle of a transfer, and it runs a random stream against a whole-word
// shift model.
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

  logic [7:0] wd[10000];
  logic [2:0] wa[10000];
  logic [1:0] wo[10000];

  pipelined_barrel_shifter #(.N(3), .OPW(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-word reference: one shift by the full amount.
  function automatic logic [7:0] model(input logic [1:0] op, input logic [2:0] a,
                                       input logic [7:0] d);
    logic [15:0] dd;
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return $signed(d) >>> a;
      default: begin dd = {d, d}; return dd[a +: 8]; end
    endcase
  endfunction

  // Handshakes are sampled at the falling edge. The transfer completes at
  // the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_amt, in_data));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single word with out_ready high. This checks the latency and the
  // one-cycle output pulse.
  task automatic run_one(input string tag, input logic [1:0] op, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] exp, input logic expz);
    in_valid = 1'b1; in_op = op; in_amt = a; in_data = d;
    tick();
    in_valid = 1'b0;
    chk({tag, "_v_t0"}, out_valid, 0);
    tick();
    chk({tag, "_v_t1"}, out_valid, 0);
    tick();
    chk({tag, "_v_t2"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_zero"}, out_zero, expz);
    tick();
    chk({tag, "_v_after"}, out_valid, 0);
  endtask

  // Streams n words from wd/wa/wo. out_ready is either low in the window
  // [st_start, st_start+st_len) or random.
  task automatic stream(input string tag, input int n, input int st_start,
                        input int st_len, input bit rnd);
    int         i, c, budget;
    bit         was_stall;
    logic [7:0] hold_d;
    logic       hold_z;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    i = 0; c = 0; was_stall = 0; hold_d = '0; hold_z = 1'b0;
    budget = 4*n + 200;
    while (got_q.size() < n && c < budget) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= st_start && c < st_start + st_len);
      if (i < n) begin
        in_valid = 1'b1; in_data = wd[i]; in_amt = wa[i]; in_op = wo[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (was_stall) begin
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_data"}, out_data, hold_d);
        chk({tag, "_hold_zero"}, out_zero, hold_z);
      end
      if (out_valid && !out_ready) begin
        chk({tag, "_stall_in_ready"}, in_ready, 0);
        was_stall = 1; hold_d = out_data; hold_z = out_zero;
      end else begin
        was_stall = 0;
      end
      if (in_valid && in_ready) i++;
      tick();
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_timeout"}, (c < budget) ? 32'd1 : 32'd0, 1);
    repeat (5) tick();
    chk({tag, "_in_count"}, exp_q.size(), n);
    chk({tag, "_out_count"}, got_q.size(), n);
    if (got_q.size() == n && exp_q.size() == n) begin
      for (int k = 0; k < n; k++) chk({tag, "_order"}, got_q[k], exp_q[k]);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 0);
    #11 reset_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    run_one("lsl_81_1",  2'b00, 3'd1, 8'h81, 8'h02, 1'b0);
    run_one("asr_80_3",  2'b10, 3'd3, 8'h80, 8'hF0, 1'b0);
    run_one("asr_40_3",  2'b10, 3'd3, 8'h40, 8'h08, 1'b0);
    run_one("asr_ff_7",  2'b10, 3'd7, 8'hFF, 8'hFF, 1'b0);
    run_one("asr_7f_7",  2'b10, 3'd7, 8'h7F, 8'h00, 1'b1);
    run_one("ror_81_1",  2'b11, 3'd1, 8'h81, 8'hC0, 1'b0);
    run_one("ror_0f_4",  2'b11, 3'd4, 8'h0F, 8'hF0, 1'b0);
    run_one("ror_01_7",  2'b11, 3'd7, 8'h01, 8'h02, 1'b0);
    run_one("lsr_80_7",  2'b01, 3'd7, 8'h80, 8'h01, 1'b0);
    run_one("lsr_01_1",  2'b01, 3'd1, 8'h01, 8'h00, 1'b1);
    run_one("lsl_01_7",  2'b00, 3'd7, 8'h01, 8'h80, 1'b0);
    run_one("lsl_a5_0",  2'b00, 3'd0, 8'hA5, 8'hA5, 1'b0);
    run_one("lsr_a5_0",  2'b01, 3'd0, 8'hA5, 8'hA5, 1'b0);
    run_one("asr_a5_0",  2'b10, 3'd0, 8'hA5, 8'hA5, 1'b0);
    run_one("ror_a5_0",  2'b11, 3'd0, 8'hA5, 8'hA5, 1'b0);

    for (int k = 0; k < 8; k++) begin
      wd[k] = 8'h11 * k[7:0] + 8'h0B; wa[k] = k[2:0]; wo[k] = k[1:0];
    end
    stream("b2b", 8, 1000, 0, 1'b0);
    if (got_cyc.size() == 8) chk("b2b_consecutive", got_cyc[7] - got_cyc[0], 7);

    for (int k = 0; k < 8; k++) begin
      wd[k] = 8'h93 ^ (8'h25 * k[7:0]); wa[k] = 3'(7 - k); wo[k] = 2'(k + 1);
    end
    stream("stall", 8, 4, 5, 1'b0);

    // Reset with three words in flight, the oldest held at the output.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = 2'b00; in_amt = 3'd1; in_data = 8'h10 + k[7:0];
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_zero", out_zero, 0);
    tick();
    reset_n = 1'b1; out_ready = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    repeat (6) begin
      tick();
      chk("post_rst_no_stale", out_valid, 0);
    end
    run_one("post_rst_ror", 2'b11, 3'd2, 8'h33, 8'hCC, 1'b0);

    for (int k = 0; k < 10000; k++) begin
      wd[k] = 8'($urandom); wa[k] = 3'($urandom); wo[k] = 2'($urandom);
    end
    stream("rand", 10000, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
